// File: rtl/cpu_clkgen_reset.sv
// Programmable 8088 CPU_CLK divider and CPU reset-hold generator in the AXI_CLK domain.
// Adds runtime reconfiguration, stop/single-step debug modes, a soft CPU reset and a rise counter.
module cpu_clkgen_reset #(
  parameter int unsigned DIV_W        = 5,
  parameter int unsigned DEFAULT_DIV  = 15,
  parameter int unsigned DEFAULT_HIGH = 5,
  parameter int unsigned HOLD_CYCLES  = 31,
  parameter int unsigned HOLD_W       = 5
) (
  input  logic             AXI_CLK,
  input  logic             CPU_RESET,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_high,
  input  logic             cfg_load,
  output logic             cfg_busy,
  input  logic [1:0]       run_mode,
  input  logic             step_req,
  input  logic             cpu_reset_req,
  output logic             CPU_CLK,
  output logic             CPU_CLK_RISE,
  output logic             CPU_RESET_HOLD,
  output logic             halted,
  output logic [31:0]      cycle_count
);

  typedef enum logic [1:0] {StRun, StHalting, StHalted, StStepping} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, high_q, pend_div_q, pend_high_q;
  logic [DIV_W-1:0]   div_c, high_c;
  logic               busy_q, clk_q, clk_d, rise_q, rise_d;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [31:0]        cycle_count_q;
  logic               mode_run, mode_step, leave_halt, advance, at_end, wrap, apply;

  assign mode_run   = (run_mode == 2'b00) || (run_mode == 2'b11);
  assign mode_step  = (run_mode == 2'b10);
  assign leave_halt = (state_q == StHalted) && (mode_run || (mode_step && step_req));
  // Leaving HALTED counts as an advancing edge so CPU_CLK rises on the very next cycle.
  assign advance    = (state_q != StHalted) || leave_halt;
  assign at_end     = (cnt_q == div_q - DIV_W'(1));
  assign wrap       = advance && at_end;
  assign apply      = busy_q && (wrap || (state_q == StHalted));

  always_comb begin
    div_c  = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
    high_c = cfg_high;
    if (cfg_high == '0) begin
      high_c = DIV_W'(1);
    end else if (cfg_high >= div_c) begin
      high_c = div_c - DIV_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    clk_d = 1'b0;
    if (advance) begin
      cnt_d = at_end ? '0 : cnt_q + DIV_W'(1);
      clk_d = (cnt_q < high_q);
    end
    rise_d = clk_d & ~clk_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (!mode_run) state_d = wrap ? StHalted : StHalting;
      end
      StHalting: begin
        if (mode_run)  state_d = StRun;
        else if (wrap) state_d = StHalted;
      end
      StHalted: begin
        if (mode_run)                    state_d = StRun;
        else if (mode_step && step_req)  state_d = StStepping;
      end
      StStepping: begin
        if (wrap) state_d = mode_run ? StRun : StHalted;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge AXI_CLK) begin
    if (CPU_RESET) begin
      state_q       <= StRun;
      cnt_q         <= '0;
      clk_q         <= 1'b0;
      rise_q        <= 1'b0;
      div_q         <= DIV_W'(DEFAULT_DIV);
      high_q        <= DIV_W'(DEFAULT_HIGH);
      pend_div_q    <= DIV_W'(DEFAULT_DIV);
      pend_high_q   <= DIV_W'(DEFAULT_HIGH);
      busy_q        <= 1'b0;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      clk_q         <= clk_d;
      rise_q        <= rise_d;
      cycle_count_q <= cycle_count_q + 32'(rise_d);
      if (apply) begin
        div_q  <= pend_div_q;
        high_q <= pend_high_q;
        busy_q <= 1'b0;
      end
      // A load in the same cycle as an apply re-arms busy for the following wrap.
      if (cfg_load) begin
        pend_div_q  <= div_c;
        pend_high_q <= high_c;
        busy_q      <= 1'b1;
      end
      if (cpu_reset_req) begin
        hold_cnt_q <= '0;
      end else if (rise_q && (state_q != StHalted) && (hold_cnt_q < HOLD_W'(HOLD_CYCLES))) begin
        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
      end
    end
  end

  assign cfg_busy       = busy_q;
  assign CPU_CLK        = clk_q;
  assign CPU_CLK_RISE   = rise_q;
  assign CPU_RESET_HOLD = (hold_cnt_q != HOLD_W'(HOLD_CYCLES));
  assign halted         = (state_q == StHalted);
  assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_cpu_clkgen_reset.sv
// Directed bench for cpu_clkgen_reset: clamping table plus hand sequences for hold, stop,
// step, soft reset and reset during a step.
module tb_cpu_clkgen_reset;

  logic        AXI_CLK = 1'b0;
  logic        CPU_RESET;
  logic [4:0]  cfg_div, cfg_high;
  logic        cfg_load, cfg_busy;
  logic [1:0]  run_mode;
  logic        step_req, cpu_reset_req;
  logic        CPU_CLK, CPU_CLK_RISE, CPU_RESET_HOLD, halted;
  logic [31:0] cycle_count;

  int n_vec = 0;
  int n_err = 0;

  cpu_clkgen_reset dut (
    .AXI_CLK        (AXI_CLK),
    .CPU_RESET      (CPU_RESET),
    .cfg_div        (cfg_div),
    .cfg_high       (cfg_high),
    .cfg_load       (cfg_load),
    .cfg_busy       (cfg_busy),
    .run_mode       (run_mode),
    .step_req       (step_req),
    .cpu_reset_req  (cpu_reset_req),
    .CPU_CLK        (CPU_CLK),
    .CPU_CLK_RISE   (CPU_CLK_RISE),
    .CPU_RESET_HOLD (CPU_RESET_HOLD),
    .halted         (halted),
    .cycle_count    (cycle_count)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  typedef struct {
    logic [4:0] div;
    logic [4:0] high;
    int         exp_period;
    int         exp_high;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge AXI_CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  task automatic wait_rise(input string name);
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (CPU_CLK_RISE) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_halted(input string name);
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (halted) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(name);
  endtask

  // Called at a rise sample; returns high time and period, ends at the next rise sample.
  task automatic measure(output int hi, output int per);
    bit ok = 0;
    hi  = 0;
    per = 0;
    for (int k = 0; k < 100; k++) begin
      if (CPU_CLK) hi++;
      per++;
      tick();
      if (CPU_CLK_RISE) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("measure");
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " CPU_CLK"},        32'(CPU_CLK), 0);
    check({tag, " CPU_CLK_RISE"},   32'(CPU_CLK_RISE), 0);
    check({tag, " CPU_RESET_HOLD"}, 32'(CPU_RESET_HOLD), 1);
    check({tag, " halted"},         32'(halted), 0);
    check({tag, " cfg_busy"},       32'(cfg_busy), 0);
    check({tag, " cycle_count"},    cycle_count, 0);
  endtask

  task automatic load(input logic [4:0] d, input logic [4:0] h);
    cfg_div  = d;
    cfg_high = h;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    int hi, per, n, rises, any_high, rise_at, low_at;
    logic [31:0] cc;

    vecs[0] = '{div: 5'd1,  high: 5'd0,  exp_period: 2,  exp_high: 1};
    vecs[1] = '{div: 5'd6,  high: 5'd6,  exp_period: 6,  exp_high: 5};
    vecs[2] = '{div: 5'd0,  high: 5'd0,  exp_period: 2,  exp_high: 1};
    vecs[3] = '{div: 5'd4,  high: 5'd9,  exp_period: 4,  exp_high: 3};
    vecs[4] = '{div: 5'd31, high: 5'd30, exp_period: 31, exp_high: 30};
    vecs[5] = '{div: 5'd3,  high: 5'd1,  exp_period: 3,  exp_high: 1};
    vecs[6] = '{div: 5'd20, high: 5'd0,  exp_period: 20, exp_high: 1};
    vecs[7] = '{div: 5'd15, high: 5'd5,  exp_period: 15, exp_high: 5};

    CPU_RESET = 1'b1; cfg_div = '0; cfg_high = '0; cfg_load = 1'b0;
    run_mode = 2'b00; step_req = 1'b0; cpu_reset_req = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");

    // Default clock and reset hold after release
    CPU_RESET = 1'b0;
    n = 0; rises = 0;
    for (int k = 0; k < 1000; k++) begin
      tick();
      n++;
      if (CPU_CLK_RISE) rises++;
      if (n == 1) begin
        check("first rise CPU_CLK", 32'(CPU_CLK), 1);
        check("first rise flag", 32'(CPU_CLK_RISE), 1);
      end
      if (!CPU_RESET_HOLD) break;
    end
    check("hold release cycle", n, 452);
    check("hold release rises", rises, 31);
    check("hold release cycle_count", cycle_count, 31);
    wait_rise("default rise");
    measure(hi, per);
    check("default high", hi, 5);
    check("default period", per, 15);

    // Load 9/3 at cnt=7: current period completes, busy clears at the wrap
    repeat (6) tick();
    load(5'd9, 5'd3);
    check("busy after load", 32'(cfg_busy), 1);
    repeat (6) tick();
    check("busy before wrap", 32'(cfg_busy), 1);
    tick();
    check("busy at wrap", 32'(cfg_busy), 0);
    check("clk low at wrap", 32'(CPU_CLK), 0);
    tick();
    check("rise after wrap", 32'(CPU_CLK_RISE), 1);
    measure(hi, per);
    check("9/3 high", hi, 3);
    check("9/3 period", per, 9);

    // Clamping table
    for (int v = 0; v < 8; v++) begin
      tick();
      load(vecs[v].div, vecs[v].high);
      for (int k = 0; k < 100 && cfg_busy; k++) tick();
      wait_rise($sformatf("vec%0d rise", v));
      measure(hi, per);
      check($sformatf("vec%0d high", v), hi, vecs[v].exp_high);
      check($sformatf("vec%0d period", v), per, vecs[v].exp_period);
    end

    // STOP during the high phase (cnt=1 of a 15-cycle period)
    run_mode = 2'b01;
    cc = cycle_count;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      n++;
      if (halted) break;
    end
    check("stop halts at wrap", n, 14);
    check("stop clk low", 32'(CPU_CLK), 0);
    any_high = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (CPU_CLK) any_high = 1;
    end
    check("halted clk stays low", any_high, 0);
    check("halted count frozen", cycle_count, cc);
    check("still halted", 32'(halted), 1);
    load(5'd4, 5'd2);
    check("halted load busy", 32'(cfg_busy), 1);
    tick();
    check("halted load applied", 32'(cfg_busy), 0);
    run_mode = 2'b00;
    tick();
    check("resume clk", 32'(CPU_CLK), 1);
    check("resume rise", 32'(CPU_CLK_RISE), 1);
    check("resume halted", 32'(halted), 0);
    check("resume count", cycle_count, cc + 1);
    measure(hi, per);
    check("4/2 high", hi, 2);
    check("4/2 period", per, 4);

    // Single step: three pulses 40 cycles apart, one extra pulse while stepping
    run_mode = 2'b10;
    wait_halted("step halt");
    cc = cycle_count;
    rises = 0;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      if (CPU_CLK_RISE) rises++;
      if (i == 0) check("step clk next cycle", 32'(CPU_CLK), 1);
      for (int j = 0; j < 39; j++) begin
        if (i == 0 && j == 1) step_req = 1'b1;
        tick();
        step_req = 1'b0;
        if (CPU_CLK_RISE) rises++;
      end
    end
    check("step rises", rises, 3);
    check("step count", cycle_count, cc + 3);
    check("step ends halted", 32'(halted), 1);

    // Soft CPU reset coincident with a rise
    run_mode = 2'b00;
    wait_rise("run after step");
    cpu_reset_req = 1'b1;
    tick();
    cpu_reset_req = 1'b0;
    check("soft reset hold", 32'(CPU_RESET_HOLD), 1);
    rises = 0; rise_at = 0; low_at = 0;
    for (int k = 1; k < 1000; k++) begin
      tick();
      if (CPU_CLK_RISE) begin
        rises++;
        rise_at = k;
      end
      if (!CPU_RESET_HOLD) begin
        low_at = k;
        break;
      end
    end
    check("soft reset rises", rises, 31);
    check("soft reset release lag", low_at - rise_at, 1);
    wait_rise("after soft reset");
    measure(hi, per);
    check("period after soft reset", per, 4);

    // CPU_RESET mid-step with a pending config, which must be discarded
    run_mode = 2'b10;
    wait_halted("halt before reset");
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    load(5'd9, 5'd3);
    check("pending before reset", 32'(cfg_busy), 1);
    CPU_RESET = 1'b1;
    tick();
    check_reset_state("mid-step reset");
    CPU_RESET = 1'b0;
    run_mode = 2'b00;
    tick();
    check("rise after reset", 32'(CPU_CLK_RISE), 1);
    measure(hi, per);
    check("defaults high after reset", hi, 5);
    check("defaults period after reset", per, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
